// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, synchronous imem reads and a 2-entry fetch queue toward decode.
// Optional build macro FETCH_PERF_EN adds saturating pop/flush performance counters.
module fetch_unit #(
    parameter int unsigned pc_width    = 10,
    parameter int unsigned instr_width = 9,
    parameter int unsigned off_width   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [pc_width-1:0]    start_addr,
    input  logic                   jump,
    input  logic                   branch_valid,
    input  logic [pc_width-1:0]    branch_pc,
    input  logic [off_width-1:0]   branch_off,
    input  logic                   halt_in,
    output logic                   imem_rd,
    output logic [pc_width-1:0]    imem_addr,
    input  logic [instr_width-1:0] imem_data,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [instr_width-1:0] instr_out,
    output logic [pc_width-1:0]    instr_pc,
    output logic                   busy,
    output logic                   done
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]            perf_fetched,
    output logic [15:0]            perf_flushed
`endif
);

    localparam int unsigned DEPTH = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [pc_width-1:0]    pc_q, pc_d;
    logic [1:0]             count_q, count_d;
    logic                   inflight_q, inflight_d;
    logic [pc_width-1:0]    inflight_addr_q, inflight_addr_d;
    logic [instr_width-1:0] qdata_q [DEPTH];
    logic [instr_width-1:0] qdata_d [DEPTH];
    logic [pc_width-1:0]    qpc_q [DEPTH];
    logic [pc_width-1:0]    qpc_d [DEPTH];

    logic                   pop;
    logic                   redirect;
    logic                   push_idx;
    logic [2:0]             occ;
    logic [pc_width-1:0]    off_ext;
    logic [pc_width-1:0]    target;

    // Queue head is kept in entry 0 so the decode-facing outputs come straight from flops.
    assign instr_valid = (count_q != 2'd0);
    assign instr_out   = qdata_q[0];
    assign instr_pc    = qpc_q[0];
    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_HALTED);
    assign imem_addr   = pc_q;

    assign pop      = instr_valid && instr_ready;
    assign redirect = jump && branch_valid;
    assign off_ext  = pc_width'($signed(branch_off));
    assign target   = branch_pc + off_ext;
    // Occupancy after this edge; also the slot the returning word lands in.
    assign occ      = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    assign push_idx = 1'(count_q - 2'(pop));

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        count_d         = count_q;
        inflight_d      = 1'b0;
        inflight_addr_d = inflight_addr_q;
        qdata_d         = qdata_q;
        qpc_d           = qpc_q;
        imem_rd         = 1'b0;

        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = start_addr;
                    count_d = 2'd0;
                end
            end
            S_RUN: begin
                if (redirect) begin
                    pc_d    = target;
                    count_d = 2'd0;
                end else if (halt_in) begin
                    state_d = S_HALTED;
                    count_d = 2'd0;
                end else begin
                    if (pop) begin
                        qdata_d[0] = qdata_q[1];
                        qpc_d[0]   = qpc_q[1];
                    end
                    if (inflight_q) begin
                        qdata_d[push_idx] = imem_data;
                        qpc_d[push_idx]   = inflight_addr_q;
                    end
                    count_d = 2'(occ);
                    if (occ < 3'd2) begin
                        imem_rd         = 1'b1;
                        inflight_d      = 1'b1;
                        inflight_addr_d = pc_q;
                        pc_d            = pc_q + pc_width'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            pc_q            <= '0;
            count_q         <= 2'd0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            qdata_q[0]      <= '0;
            qdata_q[1]      <= '0;
            qpc_q[0]        <= '0;
            qpc_q[1]        <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            count_q         <= count_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
            qdata_q         <= qdata_d;
            qpc_q           <= qpc_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] fetched_q, flushed_q;
    logic [16:0] fetched_sum, flushed_sum;
    logic [2:0]  flush_cnt;
    logic        start_ok;

    // Discarded work: entries left after any pop plus the word returning this cycle.
    always_comb begin
        flush_cnt = 3'd0;
        if (state_q == S_RUN && (redirect || halt_in)) begin
            flush_cnt = occ;
        end
        start_ok    = (state_q != S_RUN) && start;
        fetched_sum = 17'(fetched_q) + 17'(pop);
        flushed_sum = 17'(flushed_q) + 17'(flush_cnt);
    end

    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            fetched_q <= 16'd0;
            flushed_q <= 16'd0;
        end else begin
            fetched_q <= fetched_sum[16] ? 16'hFFFF : fetched_sum[15:0];
            flushed_q <= flushed_sum[16] ? 16'hFFFF : flushed_sum[15:0];
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: directed phases push expected (pc, word) pairs,
// a negedge monitor pops and compares every decode handshake.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [9:0] start_addr;
    logic       jump;
    logic       branch_valid;
    logic [9:0] branch_pc;
    logic [7:0] branch_off;
    logic       halt_in;
    logic       imem_rd;
    logic [9:0] imem_addr;
    logic [8:0] imem_data;
    logic       instr_valid;
    logic       instr_ready;
    logic [8:0] instr_out;
    logic [9:0] instr_pc;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic [9:0] pc;
        logic [8:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .start_addr   (start_addr),
        .jump         (jump),
        .branch_valid (branch_valid),
        .branch_pc    (branch_pc),
        .branch_off   (branch_off),
        .halt_in      (halt_in),
        .imem_rd      (imem_rd),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_out    (instr_out),
        .instr_pc     (instr_pc),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Synchronous memory: word at address a is a+100; junk when not reading.
    always @(posedge clk) begin
        if (imem_rd) imem_data <= 9'(imem_addr + 10'd100);
        else         imem_data <= 9'h155;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    task automatic push_range(input int first, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pc   = 10'(first + i);
            e.data = 9'(first + i + 100);
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 60) begin
            @(posedge clk); #1;
            i++;
        end
        instr_ready = 1'b0;
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_imem_rd"},     imem_rd,     0);
        chk({tag, "_imem_addr"},   imem_addr,   0);
        chk({tag, "_instr_valid"}, instr_valid, 0);
        chk({tag, "_instr_out"},   instr_out,   0);
        chk({tag, "_instr_pc"},    instr_pc,    0);
        chk({tag, "_busy"},        busy,        0);
        chk({tag, "_done"},        done,        0);
    endtask

    // Monitor: every accepted head must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_instr: got pc %0d word %0d with nothing expected (t=%0t)",
                         instr_pc, instr_out, $time);
            end else begin
                e = exp_q.pop_front();
                chk("sb_instr_pc",  instr_pc,  e.pc);
                chk("sb_instr_out", instr_out, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] valid_hist;
        int         rd_cnt;
        logic       bad;

        reset = 1'b1; start = 1'b0; start_addr = '0; jump = 1'b0; branch_valid = 1'b0;
        branch_pc = '0; branch_off = '0; halt_in = 1'b0; instr_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 reset = 1'b0;

        // Start at 10, ready held: first valid two cycles into RUN, then one per cycle.
        push_range(10, 8);
        instr_ready = 1'b1; start_addr = 10'd10; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("start_busy",      busy,      1);
        chk("start_imem_rd",   imem_rd,   1);
        chk("start_imem_addr", imem_addr, 10);
        valid_hist    = '0;
        valid_hist[0] = instr_valid;
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            valid_hist[k] = instr_valid;
        end
        chk("start_valid_pattern", valid_hist, 10'b1111111100);
        @(posedge clk); #1 instr_ready = 1'b0;
        chk("start_stream_consumed", exp_q.size(), 0);

        // Backpressure for 5 cycles, then release: order kept, nothing lost.
        rd_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rd_cnt += int'(imem_rd);
        end
        chk("bp_reads_at_most_2", (rd_cnt <= 2), 1);
        @(posedge clk); #1;
        push_range(18, 8);
        instr_ready = 1'b1;
        drain("bp_drain");

        // Redirect 20 + (-5) = 15 with a full queue.
        jump = 1'b1; branch_valid = 1'b1; branch_pc = 10'd20; branch_off = 8'hFB;
        @(negedge clk);
        chk("redir_cycle_no_rd", imem_rd, 0);
        @(posedge clk); #1;
        jump = 1'b0; branch_valid = 1'b0;
        push_range(15, 5);
        instr_ready = 1'b1;
        @(negedge clk);
        chk("redir_valid_dropped", instr_valid, 0);
        chk("redir_imem_rd",       imem_rd,     1);
        chk("redir_imem_addr",     imem_addr,   15);
        @(negedge clk);
        chk("redir_r2_valid", instr_valid, 0);
        @(negedge clk);
        chk("redir_r3_valid", instr_valid, 1);
        chk("redir_r3_pc",    instr_pc,    15);
        drain("redir_drain");

        // Redirect 2 + (-4) wraps to 1022; sequential fetch wraps 1023 -> 0.
        jump = 1'b1; branch_valid = 1'b1; branch_pc = 10'd2; branch_off = 8'hFC;
        @(posedge clk); #1;
        jump = 1'b0; branch_valid = 1'b0;
        push_range(1022, 4);
        instr_ready = 1'b1;
        @(negedge clk);
        chk("wrap_target_addr", imem_addr, 1022);
        drain("wrap_drain");

        // Halt with a read in flight: late word never presented.
        jump = 1'b1; branch_valid = 1'b1; branch_pc = 10'd100; branch_off = 8'h00;
        @(posedge clk); #1;
        jump = 1'b0; branch_valid = 1'b0;
        @(negedge clk);
        chk("halt_pre_rd",   imem_rd,   1);
        chk("halt_pre_addr", imem_addr, 100);
        @(posedge clk); #1 halt_in = 1'b1;
        @(negedge clk);
        chk("halt_cycle_no_rd", imem_rd, 0);
        @(posedge clk); #1;
        halt_in = 1'b0; instr_ready = 1'b1;
        @(negedge clk);
        chk("halt_done", done, 1);
        chk("halt_busy", busy, 0);
        bad = imem_rd | instr_valid;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bad = bad | imem_rd | instr_valid;
        end
        chk("halt_quiet", bad, 0);

        // Restart from HALTED at address 0.
        @(posedge clk); #1;
        push_range(0, 4);
        start_addr = 10'd0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("restart_done",      done,      0);
        chk("restart_busy",      busy,      1);
        chk("restart_imem_addr", imem_addr, 0);
        drain("restart_drain");

        // Jump and halt together: redirect to 53 wins, stays in RUN.
        jump = 1'b1; branch_valid = 1'b1; branch_pc = 10'd50; branch_off = 8'h03; halt_in = 1'b1;
        @(posedge clk); #1;
        jump = 1'b0; branch_valid = 1'b0; halt_in = 1'b0;
        push_range(53, 4);
        instr_ready = 1'b1;
        @(negedge clk);
        chk("jh_busy",      busy,      1);
        chk("jh_done",      done,      0);
        chk("jh_imem_addr", imem_addr, 53);
        drain("jh_drain");

        // Reset in the middle of a handshake.
        push_range(57, 1);
        instr_ready = 1'b1; reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk); #1 reset = 1'b0; instr_ready = 1'b0;
        chk("final_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
